fetch_unit: RTL and testbench

- Instruction-fetch sequencer for the RV32I core.
- Owns the fetch PC and issues word reads to instruction memory over a valid/ready request / in-order response interface.
- Buffers returned instructions with their PCs for decode.
- Consumes the execute-stage redirect (pcjump plus computed target) from the branch unit: flushes stale fetches and restarts at the target.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: issues word reads to imem, buffers returned
// instructions with their PCs for decode, and restarts on execute redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_OUT   = 2,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        pcjump,
  input  logic [31:0] jtarget,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        misalign
);

  localparam int CW  = $clog2(MAX_OUT) + 1;
  localparam int TAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int BAW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int BCW = BAW + 1;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fpc_q, fpc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            misalign_q, misalign_d;

  logic [31:0]     tag_mem [2**TAW];
  logic [TAW-1:0]  tag_wp_q, tag_rp_q;

  logic [31:0]     buf_data [2**BAW];
  logic [31:0]     buf_pc   [2**BAW];
  logic [BCW-1:0]  buf_wp_q, buf_rp_q;
  logic [BCW-1:0]  buf_cnt;
  logic [CW-1:0]   live;

  logic req_fire, rsp_keep, pop;

  assign buf_cnt  = buf_wp_q - buf_rp_q;
  assign live     = out_q - drop_q;
  assign inst_valid = (buf_cnt != '0);

  // Occupancy only shrinks without an accept, so a raised request stays up.
  assign imem_req_valid = (state_q == RUN) && !pcjump &&
                          (32'(out_q) < 32'(MAX_OUT)) &&
                          ((32'(buf_cnt) + 32'(live)) < 32'(BUF_DEPTH));
  assign imem_req_addr  = fpc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && !pcjump && (drop_q == '0);
  assign pop      = inst_valid && inst_ready && !pcjump;

  assign inst_data = inst_valid ? buf_data[buf_rp_q[BAW-1:0]] : '0;
  assign inst_pc   = inst_valid ? buf_pc[buf_rp_q[BAW-1:0]]   : '0;
  assign misalign  = misalign_q;

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    misalign_d = misalign_q;
    drop_d     = drop_q;
    out_d      = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (req_fire) fpc_d = fpc_q + 32'd4;
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (state_q == BOOT) state_d = RUN;
    // Redirect: everything still in flight after this cycle becomes stale.
    if (pcjump) begin
      drop_d = out_q - CW'(imem_rsp_valid);
      if (jtarget[1:0] == 2'b00) begin
        fpc_d      = jtarget;
        state_d    = RUN;
        misalign_d = 1'b0;
      end else begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fpc_q      <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
      tag_wp_q   <= '0;
      tag_rp_q   <= '0;
      buf_wp_q   <= '0;
      buf_rp_q   <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
      if (req_fire)       tag_wp_q <= tag_wp_q + TAW'(1);
      if (imem_rsp_valid) tag_rp_q <= tag_rp_q + TAW'(1);
      if (pcjump) begin
        buf_rp_q <= buf_wp_q;
      end else begin
        if (rsp_keep) buf_wp_q <= buf_wp_q + BCW'(1);
        if (pop)      buf_rp_q <= buf_rp_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wp_q] <= fpc_q;
    if (rsp_keep) begin
      buf_data[buf_wp_q[BAW-1:0]] <= imem_rsp_data;
      buf_pc[buf_wp_q[BAW-1:0]]   <= tag_mem[tag_rp_q];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem model and a decode log.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        pcjump;
  logic [31:0] jtarget;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        misalign;

  logic        rsp_en;
  logic        mem_acc;
  logic [31:0] mem_addr;
  int          req_cnt = 0;
  logic [31:0] pend[$];
  logic [31:0] dpc[$];
  logic [31:0] ddat[$];

  int checks   = 0;
  int failures = 0;
  int b, rb;

  fetch_unit #(.RESET_PC(32'h0), .MAX_OUT(2), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pcjump(pcjump), .jtarget(jtarget),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-order memory: one cycle latency while rsp_en=1, holds responses otherwise.
  always @(posedge clk) begin
    mem_acc  = imem_req_valid && imem_req_ready;
    mem_addr = imem_req_addr;
    if (mem_acc) req_cnt++;
    #2;
    if (mem_acc) pend.push_back(mem_addr);
    if (!rst_n) pend.delete();
    if (rst_n && rsp_en && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend.pop_front() ^ K;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && inst_valid && inst_ready && !pcjump) begin
      dpc.push_back(inst_pc);
      ddat.push_back(inst_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_at(input int i);
    return (i < dpc.size()) ? dpc[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] dat_at(input int i);
    return (i < ddat.size()) ? ddat[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic wait_deliv(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (dpc.size() < target && n < budget) begin
      next();
      n++;
    end
    chk(tag, 32'(dpc.size() >= target), 32'd1);
  endtask

  task automatic chk_seq(input string tag, input int base, input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_pc"},   pc_at(base + i),  pc0 + 32'(4 * i));
      chk({tag, "_data"}, dat_at(base + i), (pc0 + 32'(4 * i)) ^ K);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    pcjump = 1'b0; jtarget = '0; rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr",  imem_req_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc",   inst_pc, 32'h0);
    chk("rst_misalign",  32'(misalign), 32'd0);

    // Reset release and first requests
    next(); rst_n = 1'b1;
    @(negedge clk); chk("boot_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk); chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    wait_deliv(3, 30, "start_deliv");
    chk_seq("start", 0, 32'h0, 3);

    // Backpressure: restart at 0x0 with decode stalled
    pcjump = 1'b1; jtarget = 32'h0; inst_ready = 1'b0;
    next(); pcjump = 1'b0; rb = req_cnt; b = dpc.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("bp_valid", 32'(inst_valid), 32'd1);
        chk("bp_head_pc", inst_pc, 32'h0);
      end
      next();
    end
    chk("bp_req_cnt", 32'(req_cnt - rb), 32'd2);
    chk("bp_no_deliv", 32'(dpc.size() - b), 32'd0);
    chk("bp_head_data", inst_data, K);
    inst_ready = 1'b1; b = dpc.size();
    wait_deliv(b + 4, 40, "bp_deliv");
    chk_seq("bp_resume", b, 32'h0, 4);

    // Redirect with two requests in flight
    rsp_en = 1'b0;
    repeat (8) next();
    @(negedge clk);
    chk("two_out_pend", 32'(pend.size()), 32'd2);
    chk("two_out_no_req", 32'(imem_req_valid), 32'd0);
    next(); pcjump = 1'b1; jtarget = 32'h100; b = dpc.size();
    next(); pcjump = 1'b0; rsp_en = 1'b1;
    wait_deliv(b + 2, 30, "redir_deliv");
    chk_seq("redir", b, 32'h100, 2);

    // Redirect coinciding with a response and a decode pop
    rsp_en = 1'b0;
    repeat (8) next();
    rsp_en = 1'b1; inst_ready = 1'b0;
    next(); pcjump = 1'b1; jtarget = 32'h300; inst_ready = 1'b1; b = dpc.size();
    @(negedge clk);
    chk("coinc_rsp", 32'(imem_rsp_valid), 32'd1);
    chk("coinc_head", 32'(inst_valid), 32'd1);
    next(); pcjump = 1'b0;
    wait_deliv(b + 1, 30, "coinc_deliv");
    chk_seq("coinc", b, 32'h300, 1);

    // Misaligned target with stale requests outstanding
    rsp_en = 1'b0;
    repeat (8) next();
    pcjump = 1'b1; jtarget = 32'h102;
    next(); pcjump = 1'b0; rsp_en = 1'b1; rb = req_cnt; b = dpc.size();
    @(negedge clk);
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_no_req", 32'(imem_req_valid), 32'd0);
    repeat (6) next();
    @(negedge clk);
    chk("mis_drained", 32'(pend.size()), 32'd0);
    chk("mis_req_cnt", 32'(req_cnt - rb), 32'd0);
    chk("mis_no_deliv", 32'(dpc.size() - b), 32'd0);
    chk("mis_sticky", 32'(misalign), 32'd1);
    next(); pcjump = 1'b1; jtarget = 32'h200;
    next(); pcjump = 1'b0; b = dpc.size();
    @(negedge clk);
    chk("mis_clear", 32'(misalign), 32'd0);
    wait_deliv(b + 2, 30, "mis_deliv");
    chk_seq("mis_resume", b, 32'h200, 2);

    // Address wrap
    pcjump = 1'b1; jtarget = 32'hFFFF_FFF8;
    next(); pcjump = 1'b0; b = dpc.size();
    wait_deliv(b + 3, 30, "wrap_deliv");
    chk_seq("wrap", b, 32'hFFFF_FFF8, 3);

    // Mid-stream asynchronous reset
    inst_ready = 1'b0;
    repeat (6) next();
    @(negedge clk);
    chk("prerst_valid", 32'(inst_valid), 32'd1);
    next(); rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_req_addr",  imem_req_addr, 32'h0);
    chk("arst_inst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst_data", inst_data, 32'h0);
    chk("arst_inst_pc",   inst_pc, 32'h0);
    chk("arst_misalign",  32'(misalign), 32'd0);
    repeat (2) next();
    rst_n = 1'b1; inst_ready = 1'b1; b = dpc.size();
    @(negedge clk);
    chk("rerst_boot", 32'(imem_req_valid), 32'd0);
    wait_deliv(b + 1, 30, "rerst_deliv");
    chk_seq("rerst", b, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
